// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, NUM_RD
// combinational read ports, optional hardwired-zero entry 0, optional
// same-cycle write-to-read bypass, and a clear sweep that zeroes every entry
// after reset or on request so no entry is ever read back undefined.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam bit ZERO_EN = ZERO_REG[0];
  localparam bit BYP_EN  = BYPASS[0];

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]   cnt_nxt_s;
  logic                ready_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                active_s;
  logic                sweep_we_s;
  logic                wr0_s;
  logic                wr1_s;
  logic                byp_s;
  logic [NUM_RD*DATA_W-1:0] rd_s;

  // Next-state and clear-counter logic of the sweep sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        // Counter wraps naturally after the last entry; that wrap ends the sweep.
        cnt_nxt_s = cnt_r + ADDR_ONE;
        if (cnt_r == ADDR_LAST) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_READY: begin
        if (clr) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = ADDR_ZERO;
        end else begin
          state_nxt_s = ST_READY;
          cnt_nxt_s   = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = ADDR_ZERO;
      end
    endcase
  end

  // Sequencer state, clear counter and registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      cnt_r   <= ADDR_ZERO;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= (state_nxt_s == ST_READY);
    end
  end

  // Write qualification: user writes only in READY without a clear request;
  // entry 0 is never written when it is hardwired to zero.
  always_comb begin
    active_s   = (state_r == ST_READY) && !clr;
    sweep_we_s = (state_r == ST_CLEAR);
    wr0_s      = active_s && we0 && !(ZERO_EN && (wa0 == ADDR_ZERO));
    wr1_s      = active_s && we1 && !(ZERO_EN && (wa1 == ADDR_ZERO));
    byp_s      = BYP_EN && active_s;
  end

  // Storage array; port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (sweep_we_s) begin
      mem_r[cnt_r] <= DATA_ZERO;
    end else begin
      if (wr0_s) begin
        mem_r[wa0] <= wd0;
      end
      if (wr1_s) begin
        mem_r[wa1] <= wd1;
      end
    end
  end

  // Combinational read ports with zero-entry, clear masking and bypass.
  always_comb begin
    logic [ADDR_W-1:0] a_s;
    rd_s = {(NUM_RD*DATA_W){1'b0}};
    a_s  = ADDR_ZERO;
    for (int i = 0; i < NUM_RD; i++) begin
      a_s = ra[i*ADDR_W +: ADDR_W];
      if (ZERO_EN && (a_s == ADDR_ZERO)) begin
        rd_s[i*DATA_W +: DATA_W] = DATA_ZERO;
      end else if (state_r != ST_READY) begin
        rd_s[i*DATA_W +: DATA_W] = DATA_ZERO;
      end else if (byp_s && we1 && (wa1 == a_s)) begin
        rd_s[i*DATA_W +: DATA_W] = wd1;
      end else if (byp_s && we0 && (wa0 == a_s)) begin
        rd_s[i*DATA_W +: DATA_W] = wd0;
      end else begin
        rd_s[i*DATA_W +: DATA_W] = mem_r[a_s];
      end
    end
  end

  assign ready = ready_r;
  assign rd    = rd_s;

endmodule
